// File: rtl/sm83_pkg.sv
// -----------------------------------------------------------------------------
// sm83_pkg
//   Shared constants and types for the SM83 instruction-register / fetch
//   control slice.
//   Contents:
//     OPC_PREFIX_CB  CB prefix opcode byte
//     OPC_NOP        NOP opcode byte
//     ir_state_t     fetch-control FSM states (RUN, HALT, INTR)
//     is_alu_op()    8-bit ALU opcode classifier used for the in_alu flag
// -----------------------------------------------------------------------------
package sm83_pkg;

   localparam logic [7:0] OPC_PREFIX_CB = 8'hCB;
   localparam logic [7:0] OPC_NOP       = 8'h00;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      INTR = 2'd2
   } ir_state_t;

   // 8-bit ALU group: 10_xxx_rrr (register operand) and 11_xxx_110
   // (immediate operand). Only meaningful in the unprefixed bank.
   function automatic logic is_alu_op(input logic [7:0] op, input logic cb);
      return !cb && ((op[7:6] == 2'b10) ||
                     ((op[7:6] == 2'b11) && (op[2:0] == 3'b110)));
   endfunction

endpackage

// File: rtl/sm83_ir_ctrl_if.sv
// -----------------------------------------------------------------------------
// sm83_ir_ctrl_if
//   Bundle between the fetch/M-cycle sequencer and the instruction-register
//   control block.
//   Sequencer -> IR control : data_in, fetch_done, op_done, int_pending,
//                             ei_op, di_op, reti_op, halt_op
//   IR control -> decoder   : opcode, bank_cb, intr_entry, in_alu, ime,
//                             halted, pc_inc
//   Modports:
//     master  sequencer side (drives strobes, observes IR state)
//     slave   IR control side (sm83_ir_ctrl)
// -----------------------------------------------------------------------------
interface sm83_ir_ctrl_if;

   logic [7:0] data_in;
   logic       fetch_done;
   logic       op_done;
   logic       int_pending;
   logic       ei_op;
   logic       di_op;
   logic       reti_op;
   logic       halt_op;

   logic [7:0] opcode;
   logic       bank_cb;
   logic       intr_entry;
   logic       in_alu;
   logic       ime;
   logic       halted;
   logic       pc_inc;

   modport master (
      output data_in, fetch_done, op_done, int_pending,
             ei_op, di_op, reti_op, halt_op,
      input  opcode, bank_cb, intr_entry, in_alu, ime, halted, pc_inc
   );

   modport slave (
      input  data_in, fetch_done, op_done, int_pending,
             ei_op, di_op, reti_op, halt_op,
      output opcode, bank_cb, intr_entry, in_alu, ime, halted, pc_inc
   );

endinterface

// File: rtl/sm83_ime.sv
// -----------------------------------------------------------------------------
// sm83_ime
//   Interrupt master enable with the one-instruction EI delay.
//   Ports:
//     clk, reset_n   core clock, asynchronous active-low reset
//     op_done        last M-cycle of the current instruction
//     fetch_done     an opcode fetch completes (already qualified by RUN)
//     ei_op, di_op, reti_op   instruction strobes, sampled at op_done
//     dispatch       interrupt is being taken this cycle
//     ime            interrupt master enable (registered)
//   Priority at op_done: DI > RETI > EI. op_done effects override the
//   delayed-EI fetch effect when both land in the same cycle; dispatch
//   always leaves IME cleared.
// -----------------------------------------------------------------------------
module sm83_ime (
   input  logic clk,
   input  logic reset_n,
   input  logic op_done,
   input  logic fetch_done,
   input  logic ei_op,
   input  logic di_op,
   input  logic reti_op,
   input  logic dispatch,
   output logic ime
);

   logic ime_q, ime_d;
   logic ei_dly_q, ei_dly_d;

   always_comb begin
      ime_d    = ime_q;
      ei_dly_d = ei_dly_q;

      // Delayed EI lands on the fetch of the instruction after EI. dispatch
      // in this cycle was computed from the old ime, so that one
      // instruction always runs before an interrupt can be taken.
      if (fetch_done && ei_dly_q) begin
         ime_d    = 1'b1;
         ei_dly_d = 1'b0;
      end

      if (op_done) begin
         if (di_op) begin
            ime_d    = 1'b0;
            ei_dly_d = 1'b0;
         end else if (reti_op) begin
            ime_d = 1'b1;
         end else if (ei_op) begin
            ei_dly_d = 1'b1;
         end
      end

      if (dispatch) begin
         ime_d    = 1'b0;
         ei_dly_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ime_q    <= 1'b0;
         ei_dly_q <= 1'b0;
      end else begin
         ime_q    <= ime_d;
         ei_dly_q <= ei_dly_d;
      end
   end

   assign ime = ime_q;

endmodule

// File: rtl/sm83_ir_ctrl.sv
// -----------------------------------------------------------------------------
// sm83_ir_ctrl
//   Instruction register and fetch control of the SM83 core. Latches the
//   fetched opcode and tracks the CB bank, interrupt-entry pseudo-op,
//   IME / EI delay and HALT, feeding the opcode decoder with registered
//   opcode, bank_cb, intr_entry and in_alu.
//   Parameters:
//     RESET_OPCODE   opcode after reset and on interrupt entry (NOP)
//   Ports:
//     clk            core clock, all state on posedge
//     reset_n        asynchronous active-low reset
//     bus            sm83_ir_ctrl_if.slave (strobes in, IR state out;
//                    pc_inc is the only combinational output)
//   Build option:
//     SM83_HALT_BUG_EN  when defined, HALT with a pending interrupt and
//                       IME=0 sets hbug so the next fetch does not
//                       advance PC (the byte after HALT is read twice).
// -----------------------------------------------------------------------------
module sm83_ir_ctrl
   import sm83_pkg::*;
#(
   parameter logic [7:0] RESET_OPCODE = OPC_NOP
) (
   input  logic            clk,
   input  logic            reset_n,
   sm83_ir_ctrl_if.slave   bus
);

   ir_state_t  state_q, state_d;
   logic [7:0] opcode_q, opcode_d;
   logic       bank_cb_q, bank_cb_d;
   logic       intr_entry_q, intr_entry_d;
   logic       in_alu_q, in_alu_d;
   logic       halted_q, halted_d;
   logic       hbug_q, hbug_d;

   logic       fetch_ok;
   logic       cb_pending;
   logic       dispatch;
   logic       halt_req;
   logic       ime;

   // Fetches only count while running; in HALT the opcode is held and in
   // INTR the dispatch sequence owns the bus.
   assign fetch_ok   = bus.fetch_done && (state_q == RUN);

   // The current opcode is a CB prefix whose suffix has not been fetched
   // yet; no interrupt may split the pair.
   assign cb_pending = (opcode_q == OPC_PREFIX_CB) && !bank_cb_q && !intr_entry_q;

   assign dispatch   = fetch_ok && bus.int_pending && ime && !cb_pending;
   assign halt_req   = bus.op_done && bus.halt_op && (state_q == RUN);

   sm83_ime u_ime (
      .clk        (clk),
      .reset_n    (reset_n),
      .op_done    (bus.op_done),
      .fetch_done (fetch_ok),
      .ei_op      (bus.ei_op),
      .di_op      (bus.di_op),
      .reti_op    (bus.reti_op),
      .dispatch   (dispatch),
      .ime        (ime)
   );

   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      bank_cb_d    = bank_cb_q;
      intr_entry_d = intr_entry_q;
      in_alu_d     = in_alu_q;
      halted_d     = halted_q;
      hbug_d       = hbug_q;

      case (state_q)
         RUN: begin
            if (fetch_ok) begin
               hbug_d = 1'b0;
            end

            if (fetch_ok && !dispatch) begin
               opcode_d  = bus.data_in;
               bank_cb_d = cb_pending;
               in_alu_d  = is_alu_op(bus.data_in, cb_pending);
            end

            if (halt_req) begin
`ifdef SM83_HALT_BUG_EN
               if (bus.int_pending && !ime) begin
                  hbug_d = 1'b1;
               end else begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end
`else
               if (!(bus.int_pending && !ime)) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end
`endif
            end

            // Interrupt entry replaces the fetched byte with a NOP pseudo-op.
            if (dispatch) begin
               state_d      = INTR;
               opcode_d     = RESET_OPCODE;
               bank_cb_d    = 1'b0;
               in_alu_d     = 1'b0;
               intr_entry_d = 1'b1;
               halted_d     = 1'b0;
            end
         end

         HALT: begin
            // Wake on any pending interrupt; whether it is taken is decided
            // by ime at the next fetch.
            if (bus.int_pending) begin
               state_d  = RUN;
               halted_d = 1'b0;
            end
         end

         INTR: begin
            if (bus.op_done) begin
               state_d      = RUN;
               intr_entry_d = 1'b0;
            end
         end

         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= RUN;
         opcode_q     <= RESET_OPCODE;
         bank_cb_q    <= 1'b0;
         intr_entry_q <= 1'b0;
         in_alu_q     <= 1'b0;
         halted_q     <= 1'b0;
         hbug_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         bank_cb_q    <= bank_cb_d;
         intr_entry_q <= intr_entry_d;
         in_alu_q     <= in_alu_d;
         halted_q     <= halted_d;
         hbug_q       <= hbug_d;
      end
   end

   assign bus.opcode     = opcode_q;
   assign bus.bank_cb    = bank_cb_q;
   assign bus.intr_entry = intr_entry_q;
   assign bus.in_alu     = in_alu_q;
   assign bus.ime        = ime;
   assign bus.halted     = halted_q;
   assign bus.pc_inc     = fetch_ok && !dispatch && !hbug_q;

endmodule

// File: tb/tb_sm83_ir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sm83_ir_ctrl
//   Scoreboard bench for sm83_ir_ctrl. Each transaction drives one cycle of
//   sequencer strobes; expected combinational values are pushed to comb_q
//   and compared before the clock edge, expected registered values are
//   pushed to reg_q and compared just after it.
// -----------------------------------------------------------------------------
module tb_sm83_ir_ctrl;

   logic clk;
   logic reset_n;

   sm83_ir_ctrl_if bus ();

   sm83_ir_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      tag;
      logic [7:0] val;
   } exp_t;

   exp_t comb_q[$];
   exp_t reg_q[$];

   int tests_run    = 0;
   int tests_failed = 0;
   int txn_cnt      = 0;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %02h expected %02h (txn %0d)", tag, got, exp, txn_cnt);
      end
   endtask

   function automatic logic [7:0] obs(input string tag);
      if (tag == "opcode")  return bus.opcode;
      if (tag == "bank_cb") return {7'd0, bus.bank_cb};
      if (tag == "intr")    return {7'd0, bus.intr_entry};
      if (tag == "in_alu")  return {7'd0, bus.in_alu};
      if (tag == "ime")     return {7'd0, bus.ime};
      if (tag == "halted")  return {7'd0, bus.halted};
      if (tag == "pc_inc")  return {7'd0, bus.pc_inc};
      return 8'hEE;
   endfunction

   task automatic exp_c(input string tag, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      comb_q.push_back(e);
   endtask

   task automatic exp_r(input string tag, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      reg_q.push_back(e);
   endtask

   task automatic flush(input bit reg_side);
      exp_t e;
      if (reg_side) begin
         while (reg_q.size() > 0) begin
            e = reg_q.pop_front();
            check_val(e.tag, obs(e.tag), e.val);
         end
      end else begin
         while (comb_q.size() > 0) begin
            e = comb_q.pop_front();
            check_val(e.tag, obs(e.tag), e.val);
         end
      end
   endtask

   task automatic drive(input logic fd, input logic od, input logic [7:0] d,
                        input logic ip, input logic ei, input logic di,
                        input logic reti, input logic halt);
      bus.fetch_done  = fd;
      bus.op_done     = od;
      bus.data_in     = d;
      bus.int_pending = ip;
      bus.ei_op       = ei;
      bus.di_op       = di;
      bus.reti_op     = reti;
      bus.halt_op     = halt;
   endtask

   // Called one time unit after a rising edge with inputs already driven.
   task automatic tick();
      #1;
      flush(1'b0);
      @(posedge clk);
      #1;
      txn_cnt++;
      $display("[TB] txn %0d: fd=%0b od=%0b d=%02h ip=%0b ei/di/reti/halt=%0b%0b%0b%0b -> opcode=%02h cb=%0b intr=%0b alu=%0b ime=%0b halted=%0b",
               txn_cnt, bus.fetch_done, bus.op_done, bus.data_in, bus.int_pending,
               bus.ei_op, bus.di_op, bus.reti_op, bus.halt_op,
               bus.opcode, bus.bank_cb, bus.intr_entry, bus.in_alu, bus.ime, bus.halted);
      flush(1'b1);
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic exp_reset_state();
      exp_c("opcode", 8'h00);
      exp_c("bank_cb", 8'd0);
      exp_c("intr", 8'd0);
      exp_c("in_alu", 8'd0);
      exp_c("ime", 8'd0);
      exp_c("halted", 8'd0);
      exp_c("pc_inc", 8'd0);
   endtask

   logic [7:0] hbug_pc;

   initial begin
`ifdef SM83_HALT_BUG_EN
      hbug_pc = 8'd0;
`else
      hbug_pc = 8'd1;
`endif
      reset_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #6;
      exp_reset_state();
      flush(1'b0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Plain fetch of an ALU opcode.
      drive(1, 0, 8'h80, 0, 0, 0, 0, 0);
      exp_c("pc_inc", 1); exp_r("opcode", 8'h80); exp_r("in_alu", 1); exp_r("bank_cb", 0);
      tick();
      drive(0, 1, 8'h00, 0, 0, 0, 1, 0);   // RETI sets ime
      exp_r("ime", 1);
      tick();

      // CB prefix pair: no dispatch between prefix and suffix.
      drive(1, 0, 8'hCB, 0, 0, 0, 0, 0);
      exp_c("pc_inc", 1); exp_r("opcode", 8'hCB); exp_r("bank_cb", 0); exp_r("in_alu", 0);
      tick();
      drive(0, 0, 8'h00, 1, 0, 0, 0, 0);
      exp_r("intr", 0);
      tick();
      drive(1, 0, 8'h37, 1, 0, 0, 0, 0);
      exp_c("pc_inc", 1); exp_r("opcode", 8'h37); exp_r("bank_cb", 1);
      exp_r("in_alu", 0); exp_r("intr", 0); exp_r("ime", 1);
      tick();
      drive(1, 0, 8'h12, 1, 0, 0, 0, 0);   // after suffix dispatch is allowed
      exp_c("pc_inc", 0); exp_r("intr", 1); exp_r("opcode", 8'h00);
      exp_r("bank_cb", 0); exp_r("ime", 0);
      tick();
      drive(0, 1, 8'h00, 0, 0, 0, 0, 0);
      exp_r("intr", 0);
      tick();

      // EI then NOP with interrupt pending: one instruction after EI.
      drive(1, 0, 8'hFB, 1, 0, 0, 0, 0);
      exp_c("pc_inc", 1); exp_r("opcode", 8'hFB); exp_r("ime", 0); exp_r("intr", 0);
      tick();
      drive(0, 1, 8'h00, 1, 1, 0, 0, 0);
      exp_r("ime", 0);
      tick();
      drive(1, 0, 8'h00, 1, 0, 0, 0, 0);
      exp_c("pc_inc", 1); exp_r("opcode", 8'h00); exp_r("ime", 1); exp_r("intr", 0);
      tick();
      drive(1, 0, 8'h3E, 1, 0, 0, 0, 0);
      exp_c("pc_inc", 0); exp_r("intr", 1); exp_r("ime", 0); exp_r("opcode", 8'h00);
      tick();
      drive(0, 1, 8'h00, 0, 0, 0, 0, 0);
      exp_r("intr", 0);
      tick();
      drive(1, 0, 8'hFE, 0, 0, 0, 0, 0);
      exp_c("pc_inc", 1); exp_r("opcode", 8'hFE); exp_r("in_alu", 1);
      tick();

      // HALT with ime=1, wake on interrupt, then dispatch.
      drive(0, 1, 8'h00, 0, 0, 0, 1, 0);
      exp_r("ime", 1);
      tick();
      drive(0, 1, 8'h00, 0, 0, 0, 0, 1);
      exp_r("halted", 1);
      tick();
      drive(1, 0, 8'h55, 0, 0, 0, 0, 0);
      exp_r("opcode", 8'hFE); exp_r("halted", 1); exp_r("in_alu", 1);
      tick();
      drive(0, 0, 8'h00, 1, 0, 0, 0, 0);
      exp_r("halted", 0);
      tick();
      drive(1, 0, 8'h12, 1, 0, 0, 0, 0);
      exp_c("pc_inc", 0); exp_r("intr", 1); exp_r("opcode", 8'h00); exp_r("ime", 0);
      tick();
      drive(0, 1, 8'h00, 0, 0, 0, 0, 0);
      exp_r("intr", 0);
      tick();

      // HALT with ime=0 and interrupt pending.
      drive(0, 1, 8'h00, 1, 0, 0, 0, 1);
      exp_r("halted", 0);
      tick();
      drive(1, 0, 8'h3C, 0, 0, 0, 0, 0);
      exp_c("pc_inc", hbug_pc); exp_r("opcode", 8'h3C); exp_r("in_alu", 0);
      tick();
      drive(1, 0, 8'h04, 0, 0, 0, 0, 0);
      exp_c("pc_inc", 1); exp_r("opcode", 8'h04);
      tick();

      // DI beats EI, and leaves no delayed enable behind.
      drive(0, 1, 8'h00, 0, 0, 0, 1, 0);
      exp_r("ime", 1);
      tick();
      drive(0, 1, 8'h00, 0, 1, 1, 0, 0);
      exp_r("ime", 0);
      tick();
      drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
      exp_r("ime", 0);
      tick();
      drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
      exp_r("ime", 0);
      tick();
      // RETI beats EI: ime set immediately.
      drive(0, 1, 8'h00, 0, 1, 0, 1, 0);
      exp_r("ime", 1);
      tick();
      drive(1, 0, 8'h20, 1, 0, 0, 0, 0);
      exp_c("pc_inc", 0); exp_r("intr", 1);
      tick();

      // Asynchronous reset while in INTR.
      drive(0, 0, 8'h00, 1, 0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      exp_reset_state();
      flush(1'b0);
      #1;
      reset_n = 1'b1;
      drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
      exp_r("intr", 0); exp_r("opcode", 8'h00); exp_r("halted", 0); exp_r("ime", 0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
